debounced_key_encoder: RTL and testbench

- Parametrised successor of the keypad one-hot encoder in the microwave keypad/encoder hierarchy.
- Synchronises an N-key switch vector, debounces press and release, and encodes the pressed key to a binary digit code.
- Emits one-cycle press, release and error events for the time-entry controller.
- Holds the last code and locks out other keys until a debounced full release (n-key lockout).

---
 rtl/debounced_key_encoder.sv | 237 +++++++++++++++++++++++
 tb/tb_debounced_key_encoder.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/debounced_key_encoder.sv
// debounced_key_encoder: synchronises and debounces an N-key switch vector,
// encodes the accepted key to a binary digit code and emits one-cycle
// press / release / error events, with n-key lockout until full release.
// Optional auto-repeat of key_valid while a key is held: define KEY_REPEAT_EN.
module debounced_key_encoder #(
  parameter int unsigned N_KEYS          = 10,
  parameter int unsigned CODE_W          = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 3,
  parameter int unsigned MULTI_MODE      = 0,
  parameter int unsigned REPEAT_DELAY    = 1000,
  parameter int unsigned REPEAT_PERIOD   = 250
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [N_KEYS-1:0] keys,
  output logic [CODE_W-1:0] code,
  output logic              key_valid,
  output logic              key_err,
  output logic              key_release,
  output logic              key_held,
  output logic              all_off
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Elaboration-time parameter sanity checks
  if (N_KEYS > ((1 << CODE_W) - 1)) begin : g_chk_nkeys
    $error("N_KEYS must not exceed 2**CODE_W-1");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_chk_deb
    $error("DEBOUNCE_CYCLES must be at least 1");
  end
  if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_chk_rep
    $error("REPEAT_DELAY and REPEAT_PERIOD must be at least 1");
  end

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DEBOUNCE = 2'd1,
    S_HELD     = 2'd2,
    S_RELEASE  = 2'd3
  } state_t;

  logic [N_KEYS-1:0] sync1_q, skey_q;
  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [N_KEYS-1:0] cand_q, cand_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;
  logic              rel_q, rel_d;
  logic              held_q, held_d;

  logic [CODE_W-1:0] enc_code;
  logic              enc_hit, enc_multi, enc_valid;

`ifdef KEY_REPEAT_EN
  localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned REP_W   = $clog2(REP_MAX + 1);
  localparam logic [REP_W-1:0] REP_FIRST = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] REP_NEXT  = REP_W'(REPEAT_PERIOD - 1);

  logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
  logic             rep_first_q, rep_first_d;
  logic             press_ok_q, press_ok_d;
  logic [REP_W-1:0] rep_target;
`endif

  // Two-flop synchroniser on the raw switch vector
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      skey_q  <= '0;
    end else begin
      sync1_q <= keys;
      skey_q  <= sync1_q;
    end
  end

  // Encode the debounce candidate; highest set bit wins, multi-hot flagged
  always_comb begin
    enc_code  = '0;
    enc_hit   = 1'b0;
    enc_multi = 1'b0;
    for (int unsigned i = 0; i < N_KEYS; i++) begin
      if (cand_q[i]) begin
        if (enc_hit) enc_multi = 1'b1;
        enc_hit  = 1'b1;
        enc_code = CODE_W'(N_KEYS - 1 - i);
      end
    end
    enc_valid = enc_hit && (!enc_multi || (MULTI_MODE != 0));
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    code_d  = code_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    rel_d   = 1'b0;
`ifdef KEY_REPEAT_EN
    rep_cnt_d   = '0;
    rep_first_d = 1'b1;
    press_ok_d  = press_ok_q;
    rep_target  = rep_first_q ? REP_FIRST : REP_NEXT;
`endif

    if (!enable) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      code_d  = '0;
`ifdef KEY_REPEAT_EN
      press_ok_d = 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (skey_q != '0) begin
            state_d = S_DEBOUNCE;
            cand_d  = skey_q;
            cnt_d   = '0;
          end
        end
        S_DEBOUNCE: begin
          if (skey_q == '0) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end else if (skey_q != cand_q) begin
            cand_d = skey_q;
            cnt_d  = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = S_HELD;
            cnt_d   = '0;
            if (enc_valid) begin
              code_d  = enc_code;
              valid_d = 1'b1;
            end else begin
              err_d = 1'b1;
            end
`ifdef KEY_REPEAT_EN
            press_ok_d = enc_valid;
`endif
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_HELD: begin
          if (skey_q == '0) begin
            state_d = S_RELEASE;
            cnt_d   = '0;
          end
`ifdef KEY_REPEAT_EN
          else if (press_ok_q) begin
            if (rep_cnt_q == rep_target) begin
              valid_d     = 1'b1;
              rep_cnt_d   = '0;
              rep_first_d = 1'b0;
            end else begin
              rep_cnt_d   = rep_cnt_q + REP_W'(1);
              rep_first_d = rep_first_q;
            end
          end
`endif
        end
        S_RELEASE: begin
          if (skey_q != '0) begin
            state_d = S_HELD;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            rel_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    held_d = (state_d == S_HELD) || (state_d == S_RELEASE);
  end

  // State, counter and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      cand_q  <= '0;
      code_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      rel_q   <= 1'b0;
      held_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cand_q  <= cand_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      rel_q   <= rel_d;
      held_q  <= held_d;
    end
  end

`ifdef KEY_REPEAT_EN
  // Auto-repeat counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_cnt_q   <= '0;
      rep_first_q <= 1'b1;
      press_ok_q  <= 1'b0;
    end else begin
      rep_cnt_q   <= rep_cnt_d;
      rep_first_q <= rep_first_d;
      press_ok_q  <= press_ok_d;
    end
  end
`endif

  assign code        = code_q;
  assign key_valid   = valid_q;
  assign key_err     = err_q;
  assign key_release = rel_q;
  assign key_held    = held_q;
  assign all_off     = (skey_q == '0);

endmodule

// File: tb/tb_debounced_key_encoder.sv
// Bench for debounced_key_encoder: two instances (error mode and priority mode)
// share one stimulus stream and are checked every cycle against a run-length
// reference model of the key event rules.
module tb_debounced_key_encoder;

  localparam int unsigned N  = 10;
  localparam int unsigned CW = 4;
  localparam int unsigned D  = 4;
  localparam int unsigned RD = 10;
  localparam int unsigned RP = 5;

  logic          clk, rst_n, enable;
  logic [N-1:0]  keys;
  logic [CW-1:0] code_a, code_b;
  logic          valid_a, valid_b, err_a, err_b, rel_a, rel_b;
  logic          held_a, held_b, off_a, off_b;

  int tests = 0;
  int fails = 0;

  debounced_key_encoder #(.N_KEYS(N), .CODE_W(CW), .DEBOUNCE_CYCLES(D), .MULTI_MODE(0),
                          .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut_a (
    .clk(clk), .rst_n(rst_n), .enable(enable), .keys(keys),
    .code(code_a), .key_valid(valid_a), .key_err(err_a), .key_release(rel_a),
    .key_held(held_a), .all_off(off_a));

  debounced_key_encoder #(.N_KEYS(N), .CODE_W(CW), .DEBOUNCE_CYCLES(D), .MULTI_MODE(1),
                          .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut_b (
    .clk(clk), .rst_n(rst_n), .enable(enable), .keys(keys),
    .code(code_b), .key_valid(valid_b), .key_err(err_b), .key_release(rel_b),
    .key_held(held_b), .all_off(off_b));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: sampled-key history plus run length of identical samples
  logic [N-1:0]  m_s1, m_s2, prev;
  int            run;
  bit            locked [2];
  bit            ok     [2];
  int            hold_run [2];
  logic [CW-1:0] e_code [2];
  bit            e_valid [2];
  bit            e_err   [2];
  bit            e_rel   [2];

  function automatic bit rep_due(input int h);
`ifdef KEY_REPEAT_EN
    return (h == int'(RD)) || (h > int'(RD) && ((h - int'(RD)) % int'(RP)) == 0);
`else
    return (h < 0);
`endif
  endfunction

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; prev = '0; run = 0;
    for (int m = 0; m < 2; m++) begin
      locked[m] = 0; ok[m] = 0; hold_run[m] = 0; e_code[m] = '0;
      e_valid[m] = 0; e_err[m] = 0; e_rel[m] = 0;
    end
  endtask

  task automatic accept(input int m, input logic [N-1:0] v);
    int hi;
    hi = 0;
    for (int i = 0; i < int'(N); i++) if (v[i]) hi = i;
    if ($countones(v) == 1 || m == 1) begin
      e_code[m]  = CW'(int'(N) - 1 - hi);
      e_valid[m] = 1;
      ok[m]      = 1;
    end else begin
      e_err[m] = 1;
      ok[m]    = 0;
    end
    locked[m]   = 1;
    hold_run[m] = 0;
  endtask

  task automatic model_edge(input logic en, input logic [N-1:0] k);
    logic [N-1:0] obs, last;
    obs  = m_s2;
    last = prev;
    m_s2 = m_s1;
    m_s1 = k;
    for (int m = 0; m < 2; m++) begin
      e_valid[m] = 0; e_err[m] = 0; e_rel[m] = 0;
    end
    if (!en) begin
      run = 0;
      for (int m = 0; m < 2; m++) begin
        locked[m] = 0; ok[m] = 0; hold_run[m] = 0; e_code[m] = '0;
      end
    end else begin
      if (run > 0 && obs == prev) run++;
      else run = 1;
      prev = obs;
      for (int m = 0; m < 2; m++) begin
        if (!locked[m]) begin
          if (obs != '0 && run == int'(D) + 1) accept(m, obs);
        end else if (obs == '0) begin
          if (run == int'(D) + 1) begin
            e_rel[m]  = 1;
            locked[m] = 0;
          end
        end else if (last == '0) begin
          hold_run[m] = 0;
        end else begin
          hold_run[m]++;
          if (ok[m] && rep_due(hold_run[m])) e_valid[m] = 1;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("a.code",    32'(code_a),  32'(e_code[0]));
    chk("a.valid",   32'(valid_a), 32'(e_valid[0]));
    chk("a.err",     32'(err_a),   32'(e_err[0]));
    chk("a.release", 32'(rel_a),   32'(e_rel[0]));
    chk("a.held",    32'(held_a),  32'(locked[0]));
    chk("a.all_off", 32'(off_a),   32'(m_s2 == '0));
    chk("b.code",    32'(code_b),  32'(e_code[1]));
    chk("b.valid",   32'(valid_b), 32'(e_valid[1]));
    chk("b.err",     32'(err_b),   32'(e_err[1]));
    chk("b.release", 32'(rel_b),   32'(e_rel[1]));
    chk("b.held",    32'(held_b),  32'(locked[1]));
    chk("b.all_off", 32'(off_b),   32'(m_s2 == '0));
  endtask

  task automatic cyc(input logic [N-1:0] k, input logic en, input int n);
    for (int c = 0; c < n; c++) begin
      keys   = k;
      enable = en;
      @(posedge clk);
      model_edge(en, k);
      #1;
      check_all();
    end
  endtask

  // Asynchronous reset pulse applied away from the clock edge
  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [N-1:0] k, last_k;
    logic         en;
    int           r, len;

    rst_n  = 1'b0;
    enable = 1'b0;
    keys   = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rst_n = 1'b1;

    cyc('0, 1'b1, 5);

    // Clean press of digit 4, then release
    cyc(10'b0000100000, 1'b1, 20);
    cyc('0, 1'b1, 15);

    // Bounce on digit 0, then a stable hold
    for (int i = 0; i < 5; i++) begin
      cyc(10'b1000000000, 1'b1, 2);
      cyc('0, 1'b1, 2);
    end
    cyc(10'b1000000000, 1'b1, 15);
    cyc('0, 1'b1, 12);

    // Two keys at once: error in one instance, digit 8 in the other
    cyc(10'b0000000011, 1'b1, 15);
    cyc('0, 1'b1, 12);

    // Lockout: hold digit 3, add digit 7, drop digit 3, release
    cyc(10'b0001000000, 1'b1, 12);
    cyc(10'b0001000100, 1'b1, 8);
    cyc(10'b0000000100, 1'b1, 8);
    cyc('0, 1'b1, 12);

    // Enable dropped mid-debounce, re-enabled with the key still down
    cyc(10'b0000100000, 1'b1, 3);
    cyc(10'b0000100000, 1'b0, 3);
    cyc(10'b0000100000, 1'b1, 12);
    cyc('0, 1'b1, 12);

    // Long hold of digit 2 (auto-repeat window when enabled)
    cyc(10'b0010000000, 1'b1, 40);
    cyc('0, 1'b1, 12);

    // Reset while held, then while debouncing
    cyc(10'b0000000010, 1'b1, 10);
    async_reset();
    cyc(10'b0000000010, 1'b1, 10);
    cyc('0, 1'b1, 12);
    cyc(10'b0000010000, 1'b1, 4);
    async_reset();
    cyc('0, 1'b1, 6);

    // Randomised segments of stable and bouncing key patterns
    last_k = '0;
    for (int s = 0; s < 60; s++) begin
      r   = int'($urandom_range(0, 9));
      len = int'($urandom_range(1, 9));
      en  = 1'b1;
      if (r <= 2)      k = '0;
      else if (r <= 6) k = N'(1) << $urandom_range(0, N - 1);
      else if (r == 7) k = N'($urandom);
      else if (r == 8) k = last_k;
      else begin
        k  = last_k;
        en = 1'b0;
      end
      cyc(k, en, len);
      last_k = k;
    end
    cyc('0, 1'b1, 15);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
